cpu_sequencer: RTL and testbench

- Multi-cycle fetch/decode/execute sequencer for the accumulator CPU (regA/regB, ALU, muxA/muxB, combinational opcode decoder).
- Owns the program counter and instruction register, and drives the instruction memory address.
- Presents the latched opcode and literal to the decoder, and gates register loads with a one-cycle execute strobe.
- Captures ALU status flags and resolves jumps, HALT and NOP locally.

---
 rtl/cpu_sequencer.sv | 138 +++++++++++++
 tb/tb_cpu_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute sequencer for the accumulator CPU: owns PC, IR and the status flags,
// resolves jumps/NOP/HALT locally and strobes register loads once per executed instruction.
module cpu_sequencer #(
  parameter int unsigned           PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                halt_req,
  output logic [PC_WIDTH-1:0] im_addr,
  input  logic [14:0]         im_data,
  output logic [6:0]          opcode,
  output logic [7:0]          literal,
  output logic                exec_en,
  input  logic                alu_z,
  input  logic                alu_n,
  input  logic                alu_c,
  output logic [2:0]          flags,
  output logic [PC_WIDTH-1:0] pc,
  output logic                retire,
  output logic                busy,
  output logic                halted,
  output logic                illegal
);

  typedef enum logic [2:0] {StIdle, StFetch, StDecode, StExec, StHalted} state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [14:0]         ir_q, ir_d;
  logic [2:0]          flags_q, flags_d;
  logic                illegal_q, illegal_d;

  logic [6:0] op;
  logic       op_loads;   // 0x00..0x24: decoder may load registers
  logic       op_alu;     // 0x04..0x24: capture ALU status
  logic       op_taken;
  logic       op_halt;
  logic       op_ill;
  logic       restart;

  assign op = ir_q[14:8];

  always_comb begin
    op_loads = 1'b0;
    op_alu   = 1'b0;
    op_taken = 1'b0;
    op_halt  = 1'b0;
    op_ill   = 1'b0;
    case (op) inside
      [7'h00:7'h03]: op_loads = 1'b1;
      [7'h04:7'h24]: begin
        op_loads = 1'b1;
        op_alu   = 1'b1;
      end
      7'h40:   op_taken = 1'b1;
      7'h41:   op_taken = flags_q[0];
      7'h42:   op_taken = ~flags_q[0];
      7'h43:   op_taken = flags_q[1];
      7'h44:   op_taken = flags_q[2];
      7'h7E:   ;
      7'h7F:   op_halt  = 1'b1;
      default: op_ill   = 1'b1;
    endcase
  end

  assign restart = start && (state_q == StIdle || state_q == StHalted);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StFetch;
      StFetch:  state_d = StDecode;
      StDecode: state_d = StExec;
      StExec:   state_d = (op_halt || halt_req) ? StHalted : StFetch;
      StHalted: if (start) state_d = StFetch;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    exec_en = (state_q == StExec) && op_loads;
    retire  = (state_q == StExec);
    busy    = (state_q == StFetch) || (state_q == StDecode) || (state_q == StExec);
    halted  = (state_q == StHalted);
  end

  // Datapath next-state
  always_comb begin
    pc_d      = pc_q;
    ir_d      = ir_q;
    flags_d   = flags_q;
    illegal_d = illegal_q;
    if (restart) begin
      pc_d      = RESET_PC;
      flags_d   = '0;
      illegal_d = 1'b0;
    end else if (state_q == StDecode) begin
      ir_d = im_data;
    end else if (state_q == StExec) begin
      if (op_taken)     pc_d = ir_q[PC_WIDTH-1:0];
      else if (!op_halt) pc_d = pc_q + PC_WIDTH'(1);
      if (op_alu) flags_d = {alu_c, alu_n, alu_z};
      if (op_ill) illegal_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      flags_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      flags_q   <= flags_d;
      illegal_q <= illegal_d;
    end
  end

  assign im_addr = pc_q;
  assign pc      = pc_q;
  assign opcode  = op;
  assign literal = ir_q[7:0];
  assign flags   = flags_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: a synchronous instruction ROM and a tiny accumulator ALU
// model surround the DUT; table vectors check end state, hand sequences check timing corners.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        halt_req;
  logic [7:0]  im_addr;
  logic [14:0] im_data;
  logic [6:0]  opcode;
  logic [7:0]  literal;
  logic        exec_en;
  logic        alu_z, alu_n, alu_c;
  logic [2:0]  flags;
  logic [7:0]  pc;
  logic        retire, busy, halted, illegal;

  cpu_sequencer #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
    .im_addr(im_addr), .im_data(im_data), .opcode(opcode), .literal(literal),
    .exec_en(exec_en), .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .flags(flags),
    .pc(pc), .retire(retire), .busy(busy), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Instruction ROM: data valid one cycle after the address.
  logic [14:0] mem [256];
  always @(posedge clk) im_data <= mem[im_addr];

  // Accumulator model: 0x02 MOV A,lit; 0x06 ADD A,lit; 0x0A SUB A,lit (carry = borrow).
  logic [7:0] a_init;
  logic [7:0] reg_a;
  logic [8:0] alu_res;
  always_comb begin
    alu_res = {1'b0, reg_a};
    case (opcode)
      7'h02:   alu_res = {1'b0, literal};
      7'h06:   alu_res = {1'b0, reg_a} + {1'b0, literal};
      7'h0A:   alu_res = {1'b0, reg_a} - {1'b0, literal};
      default: ;
    endcase
  end
  assign alu_z = (alu_res[7:0] == 8'h00);
  assign alu_n = alu_res[7];
  assign alu_c = alu_res[8];

  int exec_cnt, retire_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_a      <= a_init;
      exec_cnt   <= 0;
      retire_cnt <= 0;
    end else begin
      if (exec_en) reg_a <= alu_res[7:0];
      if (exec_en) exec_cnt <= exec_cnt + 1;
      if (retire)  retire_cnt <= retire_cnt + 1;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    start    = 1'b0;
    halt_req = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_prog(input logic [0:3][14:0] prog);
    for (int i = 0; i < 256; i++) mem[i] = 15'h7F00;
    for (int i = 0; i < 4; i++) mem[i] = prog[i];
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halted(input string name, input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!halted) chk({name, " timeout"}, 32'(halted), 32'd1);
  endtask

  typedef struct packed {
    logic [0:3][14:0] prog;
    logic [7:0]       a0;
    logic             hreq;
    logic [7:0]       exp_pc;
    logic [2:0]       exp_flags;
    logic             exp_ill;
    logic [7:0]       exp_ret;
    logic [7:0]       exp_exe;
  } vec_t;

  localparam int NVec = 10;
  vec_t vecs [NVec];

  initial begin
    logic [15:0] mask;
    vecs[0] = '{prog: {15'h0205, 15'h06FB, 15'h7F00, 15'h7F00}, a0: 8'h00, hreq: 1'b0,
                exp_pc: 8'h02, exp_flags: 3'b101, exp_ill: 1'b0, exp_ret: 8'd3, exp_exe: 8'd2};
    vecs[1] = '{prog: {15'h0A00, 15'h4110, 15'h7F00, 15'h7F00}, a0: 8'h00, hreq: 1'b0,
                exp_pc: 8'h10, exp_flags: 3'b001, exp_ill: 1'b0, exp_ret: 8'd3, exp_exe: 8'd1};
    vecs[2] = '{prog: {15'h0A00, 15'h4110, 15'h7F00, 15'h7F00}, a0: 8'h01, hreq: 1'b0,
                exp_pc: 8'h02, exp_flags: 3'b000, exp_ill: 1'b0, exp_ret: 8'd3, exp_exe: 8'd1};
    vecs[3] = '{prog: {15'h0A00, 15'h4220, 15'h7F00, 15'h7F00}, a0: 8'h01, hreq: 1'b0,
                exp_pc: 8'h20, exp_flags: 3'b000, exp_ill: 1'b0, exp_ret: 8'd3, exp_exe: 8'd1};
    vecs[4] = '{prog: {15'h0A01, 15'h4430, 15'h7F00, 15'h7F00}, a0: 8'h00, hreq: 1'b0,
                exp_pc: 8'h30, exp_flags: 3'b110, exp_ill: 1'b0, exp_ret: 8'd3, exp_exe: 8'd1};
    vecs[5] = '{prog: {15'h0A01, 15'h4333, 15'h7F00, 15'h7F00}, a0: 8'h00, hreq: 1'b0,
                exp_pc: 8'h33, exp_flags: 3'b110, exp_ill: 1'b0, exp_ret: 8'd3, exp_exe: 8'd1};
    vecs[6] = '{prog: {15'h5500, 15'h7F00, 15'h7F00, 15'h7F00}, a0: 8'h00, hreq: 1'b0,
                exp_pc: 8'h01, exp_flags: 3'b000, exp_ill: 1'b1, exp_ret: 8'd2, exp_exe: 8'd0};
    vecs[7] = '{prog: {15'h0201, 15'h0202, 15'h0203, 15'h7F00}, a0: 8'h00, hreq: 1'b1,
                exp_pc: 8'h01, exp_flags: 3'b000, exp_ill: 1'b0, exp_ret: 8'd1, exp_exe: 8'd1};
    vecs[8] = '{prog: {15'h4020, 15'h7F00, 15'h7F00, 15'h7F00}, a0: 8'h00, hreq: 1'b1,
                exp_pc: 8'h20, exp_flags: 3'b000, exp_ill: 1'b0, exp_ret: 8'd1, exp_exe: 8'd0};
    vecs[9] = '{prog: {15'h7E00, 15'h7F00, 15'h7F00, 15'h7F00}, a0: 8'h00, hreq: 1'b0,
                exp_pc: 8'h01, exp_flags: 3'b000, exp_ill: 1'b0, exp_ret: 8'd2, exp_exe: 8'd0};

    a_init   = 8'h00;
    start    = 1'b0;
    halt_req = 1'b0;
    rst_n    = 1'b0;

    // Reset and idle
    load_prog({15'h0205, 15'h06FB, 15'h7F00, 15'h7F00});
    do_reset();
    repeat (10) @(negedge clk);
    chk("idle pc", 32'(pc), 32'h0);
    chk("idle im_addr", 32'(im_addr), 32'h0);
    chk("idle busy", 32'(busy), 32'h0);
    chk("idle halted", 32'(halted), 32'h0);
    chk("idle exec count", 32'(exec_cnt), 32'h0);
    chk("idle flags", 32'(flags), 32'h0);

    // Table vectors
    for (int v = 0; v < NVec; v++) begin
      a_init = vecs[v].a0;
      load_prog(vecs[v].prog);
      do_reset();
      halt_req = vecs[v].hreq;
      pulse_start();
      wait_halted($sformatf("vec%0d", v), 100);
      chk($sformatf("vec%0d pc", v), 32'(pc), 32'(vecs[v].exp_pc));
      chk($sformatf("vec%0d flags", v), 32'(flags), 32'(vecs[v].exp_flags));
      chk($sformatf("vec%0d illegal", v), 32'(illegal), 32'(vecs[v].exp_ill));
      chk($sformatf("vec%0d retires", v), 32'(retire_cnt), 32'(vecs[v].exp_ret));
      chk($sformatf("vec%0d execs", v), 32'(exec_cnt), 32'(vecs[v].exp_exe));
      chk($sformatf("vec%0d busy", v), 32'(busy), 32'h0);
    end

    // exec_en timing, with a start pulse while busy that must be ignored
    a_init = 8'h00;
    load_prog({15'h0205, 15'h06FB, 15'h7F00, 15'h7F00});
    do_reset();
    start = 1'b1;
    mask  = '0;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge clk);
      start = (cyc == 4);
      mask[cyc] = exec_en;
      if (cyc == 1) chk("timing busy", 32'(busy), 32'h1);
    end
    start = 1'b0;
    chk("exec_en cycles", 32'(mask), 32'h0048);
    wait_halted("timing", 20);
    chk("timing pc", 32'(pc), 32'h2);
    chk("timing retires", 32'(retire_cnt), 32'd3);
    chk("timing flags", 32'(flags), 32'b101);

    // Restart from HALTED clears flags and illegal
    load_prog({15'h0A01, 15'h5500, 15'h7F00, 15'h7F00});
    do_reset();
    pulse_start();
    wait_halted("pre-restart", 40);
    chk("pre-restart flags", 32'(flags), 32'b110);
    chk("pre-restart illegal", 32'(illegal), 32'h1);
    chk("pre-restart pc", 32'(pc), 32'h2);
    pulse_start();
    chk("restart pc", 32'(pc), 32'h0);
    chk("restart flags", 32'(flags), 32'h0);
    chk("restart illegal", 32'(illegal), 32'h0);
    chk("restart busy", 32'(busy), 32'h1);
    wait_halted("restart", 40);

    // PC wrap: JMP 0xFF, NOP at 0xFF, next fetch from 0x00
    load_prog({15'h40FF, 15'h7F00, 15'h7F00, 15'h7F00});
    mem[255] = 15'h7E00;
    do_reset();
    pulse_start();
    for (int n = 0; n < 30 && retire_cnt < 2; n++) @(negedge clk);
    chk("wrap pc", 32'(pc), 32'h0);
    chk("wrap im_addr", 32'(im_addr), 32'h0);
    chk("wrap execs", 32'(exec_cnt), 32'h0);
    halt_req = 1'b1;
    wait_halted("wrap", 20);
    chk("wrap halt pc", 32'(pc), 32'hFF);
    halt_req = 1'b0;

    // Async reset in DECODE of the second instruction
    load_prog({15'h0205, 15'h06FB, 15'h7F00, 15'h7F00});
    do_reset();
    pulse_start();
    for (int n = 0; n < 20 && retire_cnt < 1; n++) @(negedge clk);
    chk("pre-abort pc", 32'(pc), 32'h1);
    @(negedge clk);
    chk("pre-abort opcode", 32'(opcode), 32'h02);
    #2 rst_n = 1'b0;
    #1;
    chk("abort pc", 32'(pc), 32'h0);
    chk("abort opcode", 32'(opcode), 32'h0);
    chk("abort literal", 32'(literal), 32'h0);
    chk("abort busy", 32'(busy), 32'h0);
    chk("abort exec_en", 32'(exec_en), 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("abort ir held", 32'({opcode, literal}), 32'h0);
    chk("abort flags", 32'(flags), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    chk("refetch addr", 32'(im_addr), 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("refetch opcode", 32'(opcode), 32'h02);
    chk("refetch exec_en", 32'(exec_en), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
